// File: rtl/spi_ss_sequencer.sv
// SPI slave-select sequencer: one active-low select per transaction, with guard time around the master transfer.
// Optional one-deep request queue when SPI_SS_QUEUE_EN is defined.
module spi_ss_sequencer #(
    parameter int NUM_SS = 5,
    parameter int SEL_W  = 3,
    parameter int GUARD  = 2,
    parameter int DW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [SEL_W-1:0]  sel,
    input  logic [DW-1:0]     wdata,
    output logic              done,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic              err,
    output logic              mstr_wrt,
    output logic [DW-1:0]     mstr_data,
    input  logic              mstr_done,
    input  logic [DW-1:0]     mstr_rdata,
    output logic [NUM_SS-1:0] ss_n
);

    // state | meaning
    // IDLE  | all selects high, waiting for a request (or a queued one)
    // SETUP | select low, counting setup guard before the start pulse
    // XFER  | master transfer running, waiting for mstr_done
    // HOLD  | select still low, counting hold guard before release

    if (NUM_SS < 1 || NUM_SS > 16) begin : g_bad_num_ss
        $error("NUM_SS out of range 1..16");
    end
    if ((1 << SEL_W) < NUM_SS) begin : g_bad_sel_w
        $error("SEL_W too narrow for NUM_SS");
    end
    if (GUARD < 1 || GUARD > 15) begin : g_bad_guard
        $error("GUARD out of range 1..15");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [3:0]        GUARD_M1 = 4'(GUARD - 1);
    localparam logic [NUM_SS-1:0] SS_IDLE  = '1;
    localparam logic [NUM_SS-1:0] SS_ONE   = NUM_SS'(1);
    localparam logic [SEL_W:0]    SEL_LIM  = (SEL_W + 1)'(NUM_SS);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [NUM_SS-1:0] ss_n_q, ss_n_d;
    logic [DW-1:0]     mstr_data_q, mstr_data_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              mstr_wrt_q, mstr_wrt_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              sel_ok;
    logic              launch;
    logic [SEL_W-1:0]  l_sel;
    logic [DW-1:0]     l_data;

    assign sel_ok = {1'b0, sel} < SEL_LIM;

`ifdef SPI_SS_QUEUE_EN
    logic              pend_v_q, pend_v_d;
    logic [SEL_W-1:0]  pend_sel_q, pend_sel_d;
    logic [DW-1:0]     pend_data_q, pend_data_d;
    logic              to_buffer;
    logic              buf_free;

    // In IDLE the buffered request leaves this cycle, so the slot is free again.
    assign to_buffer = (state_q != IDLE) || pend_v_q;
    assign buf_free  = !pend_v_q || (state_q == IDLE);
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ss_n_d      = ss_n_q;
        mstr_data_d = mstr_data_q;
        rdata_d     = rdata_q;
        mstr_wrt_d  = 1'b0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        launch      = 1'b0;
        l_sel       = sel;
        l_data      = wdata;
`ifdef SPI_SS_QUEUE_EN
        pend_v_d    = pend_v_q;
        pend_sel_d  = pend_sel_q;
        pend_data_d = pend_data_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef SPI_SS_QUEUE_EN
                if (pend_v_q) begin
                    launch   = 1'b1;
                    l_sel    = pend_sel_q;
                    l_data   = pend_data_q;
                    pend_v_d = 1'b0;
                end
`endif
            end
            SETUP: begin
                if (cnt_q == 4'd0) begin
                    mstr_wrt_d = 1'b1;
                    state_d    = XFER;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            XFER: begin
                if (mstr_done) begin
                    rdata_d = mstr_rdata;
                    cnt_d   = GUARD_M1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == 4'd0) begin
                    ss_n_d  = SS_IDLE;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (req) begin
            if (!sel_ok) begin
                err_d = 1'b1;
`ifdef SPI_SS_QUEUE_EN
            end else if (to_buffer) begin
                if (buf_free) begin
                    pend_v_d    = 1'b1;
                    pend_sel_d  = sel;
                    pend_data_d = wdata;
                end else begin
                    err_d = 1'b1;
                end
`else
            end else if (state_q != IDLE) begin
                err_d = 1'b1;
`endif
            end else begin
                launch = 1'b1;
            end
        end

        if (launch) begin
            mstr_data_d = l_data;
            ss_n_d      = ~(SS_ONE << l_sel);
            cnt_d       = GUARD_M1;
            state_d     = SETUP;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            ss_n_q      <= SS_IDLE;
            mstr_data_q <= '0;
            rdata_q     <= '0;
            mstr_wrt_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ss_n_q      <= ss_n_d;
            mstr_data_q <= mstr_data_d;
            rdata_q     <= rdata_d;
            mstr_wrt_q  <= mstr_wrt_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef SPI_SS_QUEUE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_v_q    <= 1'b0;
            pend_sel_q  <= '0;
            pend_data_q <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_sel_q  <= pend_sel_d;
            pend_data_q <= pend_data_d;
        end
    end

    assign busy = (state_q != IDLE) || pend_v_q;
`else
    assign busy = (state_q != IDLE);
`endif

    assign ss_n      = ss_n_q;
    assign mstr_wrt  = mstr_wrt_q;
    assign mstr_data = mstr_data_q;
    assign rdata     = rdata_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_ss_sequencer.sv
// Directed bench for spi_ss_sequencer at default parameters; covers both SPI_SS_QUEUE_EN builds.
module tb_spi_ss_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic [2:0]  sel = '0;
    logic [15:0] wdata = '0;
    logic        done;
    logic [15:0] rdata;
    logic        busy;
    logic        err;
    logic        mstr_wrt;
    logic [15:0] mstr_data;
    logic        mstr_done = 1'b0;
    logic [15:0] mstr_rdata = '0;
    logic [4:0]  ss_n;

    int vectors = 0;
    int miscompares = 0;
    int wrt_cnt = 0;
    int done_cnt = 0;

    spi_ss_sequencer #(.NUM_SS(5), .SEL_W(3), .GUARD(2), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .sel(sel), .wdata(wdata),
        .done(done), .rdata(rdata), .busy(busy), .err(err),
        .mstr_wrt(mstr_wrt), .mstr_data(mstr_data), .mstr_done(mstr_done),
        .mstr_rdata(mstr_rdata), .ss_n(ss_n)
    );

    always #5 clk = ~clk;

    // Event counters and the at-most-one-select-low invariant.
    always @(negedge clk) begin
        if (rst_n && mstr_wrt) wrt_cnt++;
        if (rst_n && done) done_cnt++;
        vectors++;
        if ($countones(~ss_n) > 1) begin
            miscompares++;
            $display("FAIL ss_onehot: ss_n=%b, required at most one low", ss_n);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wrt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mstr_wrt) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic master_reply(input logic [15:0] rd);
        mstr_done  = 1'b1;
        mstr_rdata = rd;
        tick();
        mstr_done  = 1'b0;
    endtask

    task automatic issue(input logic [2:0] s, input logic [15:0] d);
        req   = 1'b1;
        sel   = s;
        wdata = d;
        tick();
        req   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if (ss_n !== 5'b11111) begin miscompares++; $display("FAIL reset_ss_n: got %b want 11111", ss_n); end
        vectors++;
        if ({busy, done, mstr_wrt, err} !== 4'b0000) begin
            miscompares++; $display("FAIL reset_flags: busy/done/wrt/err got %b want 0000", {busy, done, mstr_wrt, err});
        end
        vectors++;
        if ({rdata, mstr_data} !== 32'h0) begin
            miscompares++; $display("FAIL reset_data: rdata=%h mstr_data=%h want 0", rdata, mstr_data);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bit good;
        issue(3'd3, 16'h5CEF);
        vectors++;
        if (ss_n !== 5'b10111 || mstr_wrt !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL basic_e0: ss_n=%b wrt=%b busy=%b want 10111/0/1", ss_n, mstr_wrt, busy);
        end
        tick();
        vectors++;
        if (ss_n !== 5'b10111 || mstr_wrt !== 1'b0) begin
            miscompares++; $display("FAIL basic_e1: ss_n=%b wrt=%b want 10111/0", ss_n, mstr_wrt);
        end
        tick();
        vectors++;
        if (mstr_wrt !== 1'b1 || ss_n !== 5'b10111) begin
            miscompares++; $display("FAIL basic_wrt: wrt=%b ss_n=%b want 1/10111", mstr_wrt, ss_n);
        end
        vectors++;
        if (mstr_data !== 16'h5CEF) begin miscompares++; $display("FAIL basic_mdata: got %h want 5cef", mstr_data); end
        good = 1'b1;
        for (int i = 0; i < 39; i++) begin
            tick();
            if (ss_n !== 5'b10111 || mstr_wrt !== 1'b0) good = 1'b0;
        end
        vectors++;
        if (!good) begin miscompares++; $display("FAIL basic_xfer_hold: ss_n=%b wrt=%b want 10111/0", ss_n, mstr_wrt); end
        master_reply(16'h00A5);
        vectors++;
        if (rdata !== 16'h00A5 || ss_n !== 5'b10111 || done !== 1'b0) begin
            miscompares++; $display("FAIL basic_d0: rdata=%h ss_n=%b done=%b want 00a5/10111/0", rdata, ss_n, done);
        end
        tick();
        vectors++;
        if (ss_n !== 5'b10111 || done !== 1'b0) begin
            miscompares++; $display("FAIL basic_d1: ss_n=%b done=%b want 10111/0", ss_n, done);
        end
        tick();
        vectors++;
        if (done !== 1'b1 || ss_n !== 5'b11111 || rdata !== 16'h00A5) begin
            miscompares++; $display("FAIL basic_done: done=%b ss_n=%b rdata=%h want 1/11111/00a5", done, ss_n, rdata);
        end
        tick();
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL basic_idle: done=%b busy=%b want 0/0", done, busy);
        end
    endtask

    task automatic test_invalid();
        int w0;
        logic [2:0] bad [3] = '{3'd5, 3'd6, 3'd7};
        tick();
        w0 = wrt_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(bad[i], 16'hDEAD);
            vectors++;
            if (err !== 1'b1 || ss_n !== 5'b11111 || busy !== 1'b0) begin
                miscompares++; $display("FAIL invalid_err sel=%0d: err=%b ss_n=%b busy=%b want 1/11111/0", bad[i], err, ss_n, busy);
            end
            tick();
            vectors++;
            if (err !== 1'b0) begin miscompares++; $display("FAIL invalid_pulse sel=%0d: err=%b want 0", bad[i], err); end
        end
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (wrt_cnt != w0 || ss_n !== 5'b11111) begin
            miscompares++; $display("FAIL invalid_nowrt: wrt=%0d ss_n=%b want %0d/11111", wrt_cnt - w0, ss_n, 0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        issue(3'd0, 16'h1111);
        wait_wrt(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL b2b_wrt1: no mstr_wrt within 20 cycles, want one"); end
        tick();
        master_reply(16'h7E81);
        wait_done(ok);
        vectors++;
        if (!ok || rdata !== 16'h7E81) begin
            miscompares++; $display("FAIL b2b_done1: seen=%b rdata=%h want 1/7e81", ok, rdata);
        end
        issue(3'd1, 16'h2222);
        vectors++;
        if (ss_n !== 5'b11101 || err !== 1'b0) begin
            miscompares++; $display("FAIL b2b_accept: ss_n=%b err=%b want 11101/0", ss_n, err);
        end
        wait_wrt(ok);
        vectors++;
        if (!ok || mstr_data !== 16'h2222) begin
            miscompares++; $display("FAIL b2b_wrt2: seen=%b mstr_data=%h want 1/2222", ok, mstr_data);
        end
        master_reply(16'h3C3C);
        wait_done(ok);
        vectors++;
        if (!ok || rdata !== 16'h3C3C || ss_n !== 5'b11111) begin
            miscompares++; $display("FAIL b2b_done2: seen=%b rdata=%h ss_n=%b want 1/3c3c/11111", ok, rdata, ss_n);
        end
        tick();
    endtask

`ifndef SPI_SS_QUEUE_EN
    task automatic test_busy_reject();
        bit ok;
        int w0;
        w0 = wrt_cnt;
        issue(3'd2, 16'hAAAA);
        wait_wrt(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL busy_wrt: no mstr_wrt within 20 cycles, want one"); end
        tick();
        issue(3'd0, 16'hBBBB);
        vectors++;
        if (err !== 1'b1 || ss_n !== 5'b11011) begin
            miscompares++; $display("FAIL busy_err: err=%b ss_n=%b want 1/11011", err, ss_n);
        end
        tick();
        vectors++;
        if (err !== 1'b0) begin miscompares++; $display("FAIL busy_err_pulse: err=%b want 0", err); end
        master_reply(16'hCCCC);
        wait_done(ok);
        vectors++;
        if (!ok || rdata !== 16'hCCCC || mstr_data !== 16'hAAAA) begin
            miscompares++; $display("FAIL busy_done: seen=%b rdata=%h mdata=%h want 1/cccc/aaaa", ok, rdata, mstr_data);
        end
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (wrt_cnt - w0 != 1 || busy !== 1'b0 || ss_n !== 5'b11111) begin
            miscompares++; $display("FAIL busy_one_wrt: wrts=%0d busy=%b ss_n=%b want 1/0/11111", wrt_cnt - w0, busy, ss_n);
        end
    endtask
`else
    task automatic test_queue();
        bit ok;
        int w0;
        w0 = wrt_cnt;
        issue(3'd4, 16'h4444);
        wait_wrt(ok);
        vectors++;
        if (!ok || ss_n !== 5'b01111) begin miscompares++; $display("FAIL queue_wrt1: seen=%b ss_n=%b want 1/01111", ok, ss_n); end
        tick();
        issue(3'd0, 16'h13DD);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL queue_accept: err=%b busy=%b want 0/1", err, busy); end
        issue(3'd1, 16'h9999);
        vectors++;
        if (err !== 1'b1) begin miscompares++; $display("FAIL queue_full_err: err=%b want 1", err); end
        master_reply(16'h0F0F);
        wait_done(ok);
        vectors++;
        if (!ok || rdata !== 16'h0F0F || ss_n !== 5'b11111) begin
            miscompares++; $display("FAIL queue_done1: seen=%b rdata=%h ss_n=%b want 1/0f0f/11111", ok, rdata, ss_n);
        end
        tick();
        vectors++;
        if (ss_n !== 5'b11110 || mstr_data !== 16'h13DD) begin
            miscompares++; $display("FAIL queue_launch: ss_n=%b mdata=%h want 11110/13dd", ss_n, mstr_data);
        end
        wait_wrt(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL queue_wrt2: no mstr_wrt within 20 cycles, want one"); end
        master_reply(16'h5A5A);
        wait_done(ok);
        vectors++;
        if (!ok || rdata !== 16'h5A5A) begin miscompares++; $display("FAIL queue_done2: seen=%b rdata=%h want 1/5a5a", ok, rdata); end
        for (int i = 0; i < 6; i++) tick();
        vectors++;
        if (wrt_cnt - w0 != 2 || busy !== 1'b0 || ss_n !== 5'b11111) begin
            miscompares++; $display("FAIL queue_end: wrts=%0d busy=%b ss_n=%b want 2/0/11111", wrt_cnt - w0, busy, ss_n);
        end
    endtask
`endif

    task automatic test_reset_mid();
        bit ok;
        int w0;
        int d0;
        issue(3'd1, 16'h7777);
        wait_wrt(ok);
        tick();
        vectors++;
        if (!ok || ss_n !== 5'b11101) begin miscompares++; $display("FAIL rstmid_xfer: seen=%b ss_n=%b want 1/11101", ok, ss_n); end
`ifdef SPI_SS_QUEUE_EN
        issue(3'd2, 16'h8888);
`endif
        rst_n = 1'b0;
        #2;
        vectors++;
        if (ss_n !== 5'b11111 || busy !== 1'b0 || mstr_data !== 16'h0) begin
            miscompares++; $display("FAIL rstmid_async: ss_n=%b busy=%b mdata=%h want 11111/0/0000", ss_n, busy, mstr_data);
        end
        tick();
        tick();
        rst_n = 1'b1;
        w0 = wrt_cnt;
        d0 = done_cnt;
        tick();
        master_reply(16'hFFFF);
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (wrt_cnt != w0 || done_cnt != d0 || ss_n !== 5'b11111 || busy !== 1'b0 || rdata !== 16'h0) begin
            miscompares++;
            $display("FAIL rstmid_quiet: wrts=%0d dones=%0d ss_n=%b busy=%b rdata=%h want 0/0/11111/0/0000",
                     wrt_cnt - w0, done_cnt - d0, ss_n, busy, rdata);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_invalid();
        test_back_to_back();
`ifdef SPI_SS_QUEUE_EN
        test_queue();
`else
        test_busy_reject();
`endif
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
